// File: rtl/usb4_pulse_pkg.sv
// Shared edge-select encodings and sizing helper for the level-to-pulse converter.
package usb4_pulse_pkg;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_OFF  = 2'b11
   } edge_mode_e;

   // Stretch counter holds PULSE_WIDTH-1, but never narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/multi_pul_gen_if.sv
// Level inputs, per-channel edge select, overrun clear and the resulting pulse/busy/overrun outputs.
interface multi_pul_gen_if #(
   parameter int CH = 1
);
   logic [CH-1:0]   lvl_sig;
   logic [2*CH-1:0] edge_mode;
   logic            ovr_clr;
   logic [CH-1:0]   pulse_sig;
   logic [CH-1:0]   busy;
   logic [CH-1:0]   overrun;

   modport master (
      output lvl_sig, edge_mode, ovr_clr,
      input  pulse_sig, busy, overrun
   );

   modport slave (
      input  lvl_sig, edge_mode, ovr_clr,
      output pulse_sig, busy, overrun
   );
endinterface

// File: rtl/edge_pulse_ch.sv
// One channel: sampling chain, edge select, pulse stretch counter and sticky overrun flag.
// Pulse appears SYNC_STAGES-1 cycles after the capturing edge; no backpressure, events never stall.
module edge_pulse_ch
   import usb4_pulse_pkg::*;
#(
   parameter int SYNC_STAGES = 1,
   parameter int PULSE_WIDTH = 1,
   parameter int RETRIGGER   = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       lvl_i,
   input  logic [1:0] edge_mode_i,
   input  logic       ovr_clr_i,
   output logic       pulse_o,
   output logic       busy_o,
   output logic       overrun_o
);
   localparam int            CW     = cnt_width(PULSE_WIDTH);
   localparam logic [CW-1:0] RELOAD = CW'(PULSE_WIDTH - 1);

   logic [SYNC_STAGES-1:0] s_q, s_d;
   logic                   prev_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   ovr_q, ovr_d;
   logic                   sync_lvl;
   logic                   rise, fall, edge_det, cnt_nz;

   always_comb begin
      s_d    = s_q;
      s_d[0] = lvl_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         s_d[k] = s_q[k-1];
      end
   end

   assign sync_lvl = s_q[SYNC_STAGES-1];
   assign rise     = sync_lvl & ~prev_q;
   assign fall     = ~sync_lvl & prev_q;
   assign cnt_nz   = (cnt_q != '0);

   // Mode is applied combinationally, so a change only gates edges, never a pulse in flight.
   always_comb begin
      edge_det = 1'b0;
      case (edge_mode_e'(edge_mode_i))
         EDGE_RISE: edge_det = rise;
         EDGE_FALL: edge_det = fall;
         EDGE_BOTH: edge_det = rise | fall;
         EDGE_OFF:  edge_det = 1'b0;
         default:   edge_det = 1'b0;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (edge_det && (!cnt_nz || (RETRIGGER != 0))) begin
         cnt_d = RELOAD;
      end else if (cnt_nz) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // A new overrun takes priority over a clear arriving in the same cycle.
   always_comb begin
      ovr_d = ovr_q;
      if (ovr_clr_i) begin
         ovr_d = 1'b0;
      end
      if (edge_det && cnt_nz) begin
         ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_q    <= '0;
         prev_q <= 1'b0;
         cnt_q  <= '0;
         ovr_q  <= 1'b0;
      end else begin
         s_q    <= s_d;
         prev_q <= sync_lvl;
         cnt_q  <= cnt_d;
         ovr_q  <= ovr_d;
      end
   end

   assign pulse_o   = edge_det | cnt_nz;
   assign busy_o    = cnt_nz;
   assign overrun_o = ovr_q;

endmodule

// File: rtl/multi_pul_gen.sv
// N-channel level-to-pulse converter; channels are independent copies of edge_pulse_ch.
// Latency SYNC_STAGES-1 cycles after capture; no backpressure.
module multi_pul_gen #(
   parameter int CH          = 1,
   parameter int SYNC_STAGES = 1,
   parameter int PULSE_WIDTH = 1,
   parameter int RETRIGGER   = 0
) (
   input  logic           clk,
   input  logic           reset_n,
   multi_pul_gen_if.slave bus
);

   for (genvar i = 0; i < CH; i++) begin : g_ch
      edge_pulse_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .PULSE_WIDTH (PULSE_WIDTH),
         .RETRIGGER   (RETRIGGER)
      ) u_ch (
         .clk         (clk),
         .reset_n     (reset_n),
         .lvl_i       (bus.lvl_sig[i]),
         .edge_mode_i (bus.edge_mode[2*i+1 -: 2]),
         .ovr_clr_i   (bus.ovr_clr),
         .pulse_o     (bus.pulse_sig[i]),
         .busy_o      (bus.busy[i]),
         .overrun_o   (bus.overrun[i])
      );
   end

endmodule

// File: tb/tb_multi_pul_gen.sv
// Directed bench: four multi_pul_gen configurations checked against hand-computed cycle patterns.
module tb_multi_pul_gen;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic lvl1 = 1'b0;
   logic [1:0] mode_b = 2'b10;
   logic ovr_clr1 = 1'b0;
   logic [3:0] lvl4 = 4'b0000;
   logic [7:0] mode_d = 8'b11_11_11_11;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   multi_pul_gen_if #(.CH(1)) if_a ();
   multi_pul_gen_if #(.CH(1)) if_b ();
   multi_pul_gen_if #(.CH(1)) if_c ();
   multi_pul_gen_if #(.CH(4)) if_d ();

   assign if_a.lvl_sig   = lvl1;
   assign if_a.edge_mode = 2'b00;
   assign if_a.ovr_clr   = ovr_clr1;
   assign if_b.lvl_sig   = lvl1;
   assign if_b.edge_mode = mode_b;
   assign if_b.ovr_clr   = ovr_clr1;
   assign if_c.lvl_sig   = lvl1;
   assign if_c.edge_mode = 2'b10;
   assign if_c.ovr_clr   = ovr_clr1;
   assign if_d.lvl_sig   = lvl4;
   assign if_d.edge_mode = mode_d;
   assign if_d.ovr_clr   = 1'b0;

   multi_pul_gen #(.CH(1), .SYNC_STAGES(1), .PULSE_WIDTH(1), .RETRIGGER(0)) u_a (
      .clk(clk), .reset_n(reset_n), .bus(if_a));
   multi_pul_gen #(.CH(1), .SYNC_STAGES(1), .PULSE_WIDTH(4), .RETRIGGER(0)) u_b (
      .clk(clk), .reset_n(reset_n), .bus(if_b));
   multi_pul_gen #(.CH(1), .SYNC_STAGES(1), .PULSE_WIDTH(4), .RETRIGGER(1)) u_c (
      .clk(clk), .reset_n(reset_n), .bus(if_c));
   multi_pul_gen #(.CH(4), .SYNC_STAGES(2), .PULSE_WIDTH(4), .RETRIGGER(0)) u_d (
      .clk(clk), .reset_n(reset_n), .bus(if_d));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      logic [3:0] got;
      #12;
      got = {if_a.pulse_sig, if_b.pulse_sig, if_c.pulse_sig, |if_d.pulse_sig};
      total++;
      if (got !== 4'b0000) begin
         bad++; $display("FAIL reset_pulse got=%b exp=0000", got);
      end
      got = {if_a.busy, if_b.busy, if_c.busy, |if_d.busy};
      total++;
      if (got !== 4'b0000) begin
         bad++; $display("FAIL reset_busy got=%b exp=0000", got);
      end
      got = {if_a.overrun, if_b.overrun, if_c.overrun, |if_d.overrun};
      total++;
      if (got !== 4'b0000) begin
         bad++; $display("FAIL reset_overrun got=%b exp=0000", got);
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_w1();
      lvl1 = 1'b0;
      idle(6);
      total++;
      if (if_a.pulse_sig !== 1'b0) begin
         bad++; $display("FAIL w1_idle got=%b exp=0", if_a.pulse_sig);
      end
      lvl1 = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         total++;
         if (if_a.pulse_sig !== (i == 1)) begin
            bad++; $display("FAIL w1_pulse cyc%0d got=%b exp=%b", i, if_a.pulse_sig, (i == 1));
         end
         total++;
         if (if_a.busy !== 1'b0) begin
            bad++; $display("FAIL w1_busy cyc%0d got=%b exp=0", i, if_a.busy);
         end
      end
   endtask

   task automatic test_stretch_both();
      logic [5:0] exp_p, exp_b;
      exp_p = 6'b001111;
      exp_b = 6'b001110;
      mode_b = 2'b10;
      lvl1 = 1'b0;
      idle(8);
      lvl1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i < 6) begin
            total++;
            if (if_b.pulse_sig !== exp_p[i] || if_b.busy !== exp_b[i]) begin
               bad++; $display("FAIL stretch_rise cyc%0d got=%b%b exp=%b%b", i + 1,
                               if_b.pulse_sig, if_b.busy, exp_p[i], exp_b[i]);
            end
         end
      end
      lvl1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (if_b.pulse_sig !== exp_p[i] || if_b.busy !== exp_b[i]) begin
            bad++; $display("FAIL stretch_fall cyc%0d got=%b%b exp=%b%b", i + 1,
                            if_b.pulse_sig, if_b.busy, exp_p[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_retrigger();
      logic [10:0] p0, b0, p1, b1;
      p0 = 11'b000_1111_1111;
      b0 = 11'b000_1110_1110;
      p1 = 11'b011_1111_1111;
      b1 = 11'b011_1111_1110;
      idle(8);
      for (int i = 0; i < 11; i++) begin
         if (i == 0 || i == 4) lvl1 = 1'b1;
         if (i == 2 || i == 6) lvl1 = 1'b0;
         tick();
         total++;
         if (if_b.pulse_sig !== p0[i] || if_b.busy !== b0[i]) begin
            bad++; $display("FAIL retrig0 cyc%0d got=%b%b exp=%b%b", i + 1,
                            if_b.pulse_sig, if_b.busy, p0[i], b0[i]);
         end
         total++;
         if (if_c.pulse_sig !== p1[i] || if_c.busy !== b1[i]) begin
            bad++; $display("FAIL retrig1 cyc%0d got=%b%b exp=%b%b", i + 1,
                            if_c.pulse_sig, if_c.busy, p1[i], b1[i]);
         end
      end
      total++;
      if (if_b.overrun !== 1'b1 || if_c.overrun !== 1'b1) begin
         bad++; $display("FAIL retrig_overrun got=%b%b exp=11", if_b.overrun, if_c.overrun);
      end
   endtask

   task automatic test_multi_channel();
      logic [3:0] exp;
      lvl4 = 4'b0000;
      mode_d = 8'b00_11_00_00;
      idle(4);
      lvl4 = 4'b1101;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp = (i >= 2 && i <= 5) ? 4'b1001 : 4'b0000;
         total++;
         if (if_d.pulse_sig !== exp) begin
            bad++; $display("FAIL mc_rise cyc%0d got=%b exp=%b", i, if_d.pulse_sig, exp);
         end
      end
      lvl4 = 4'b0000;
      mode_d = 8'b01_11_00_00;
      for (int i = 1; i <= 7; i++) begin
         tick();
         exp = (i >= 2 && i <= 5) ? 4'b1000 : 4'b0000;
         total++;
         if (if_d.pulse_sig !== exp) begin
            bad++; $display("FAIL mc_fall_modeoff cyc%0d got=%b exp=%b", i, if_d.pulse_sig, exp);
         end
         if (i == 3) mode_d = 8'b11_11_00_00;
      end
   endtask

   task automatic test_overrun_clear();
      ovr_clr1 = 1'b1;
      tick();
      ovr_clr1 = 1'b0;
      total++;
      if (if_b.overrun !== 1'b0) begin
         bad++; $display("FAIL ovr_clr_plain got=%b exp=0", if_b.overrun);
      end
      idle(4);
      lvl1 = 1'b1;
      tick();
      lvl1 = 1'b0;
      tick();
      ovr_clr1 = 1'b1;
      tick();
      total++;
      if (if_b.overrun !== 1'b1) begin
         bad++; $display("FAIL ovr_set_wins got=%b exp=1", if_b.overrun);
      end
      total++;
      if (if_b.pulse_sig !== 1'b1) begin
         bad++; $display("FAIL ovr_clr_pulse got=%b exp=1", if_b.pulse_sig);
      end
      tick();
      ovr_clr1 = 1'b0;
      total++;
      if (if_b.overrun !== 1'b0) begin
         bad++; $display("FAIL ovr_next_clr got=%b exp=0", if_b.overrun);
      end
      idle(6);
   endtask

   task automatic test_reset_mid_pulse();
      logic [7:0] exp_p;
      exp_p = 8'b0000_1111;
      mode_b = 2'b10;
      lvl1 = 1'b0;
      idle(6);
      lvl1 = 1'b1;
      tick();
      tick();
      total++;
      if (if_b.pulse_sig !== 1'b1 || if_b.busy !== 1'b1) begin
         bad++; $display("FAIL pre_reset got=%b%b exp=11", if_b.pulse_sig, if_b.busy);
      end
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if (if_b.pulse_sig !== 1'b0 || if_b.busy !== 1'b0) begin
         bad++; $display("FAIL async_reset got=%b%b exp=00", if_b.pulse_sig, if_b.busy);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if (if_b.pulse_sig !== exp_p[i]) begin
            bad++; $display("FAIL powerup_pulse cyc%0d got=%b exp=%b", i + 1, if_b.pulse_sig, exp_p[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_w1();
      test_stretch_both();
      test_retrigger();
      test_multi_channel();
      test_overrun_clear();
      test_reset_mid_pulse();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
